// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared state encoding and grant constants for the memory port arbiter
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    localparam logic GNT_IF  = 1'b0;
    localparam logic GNT_MEM = 1'b1;

endpackage

// File: rtl/mem_arb_rr_pick.sv
// rtl/mem_arb_rr_pick.sv - combinational two-way round-robin picker
module mem_arb_rr_pick
    import mem_port_arbiter_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic any_req,
    output logic winner
);

    always_comb begin
        any_req = req0 | req1;
        if (req0 && req1) begin
            winner = ~last_grant;
        end else if (req1) begin
            winner = GNT_MEM;
        end else begin
            winner = GNT_IF;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter and sequencer for one shared single-port memory
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req0_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [DATA_W-1:0] wdata0_i,
    input  logic              we0_i,
    input  logic              req1_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] wdata1_i,
    input  logic              we1_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              mem_we_o,
    input  logic              mem_ready_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              sel_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              done0_o,
    output logic              done1_o,
    output logic              timeout_o,
    output logic              busy_o
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

    arb_state_t        state, state_nxt;
    logic              last_grant, last_grant_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              any_req, winner;
    logic              expire;

    logic              mem_req_nxt, mem_we_nxt, sel_nxt;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic [DATA_W-1:0] mem_wdata_nxt, rdata_nxt;
    logic              done0_nxt, done1_nxt, timeout_nxt, busy_nxt;

    mem_arb_rr_pick u_pick (
        .req0       (req0_i),
        .req1       (req1_i),
        .last_grant (last_grant),
        .any_req    (any_req),
        .winner     (winner)
    );

    assign expire = (cnt == CNT_LAST);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = BUSY;
            BUSY:    if (mem_ready_i || expire) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Every port output is registered; this block computes their next values.
    always_comb begin
        mem_req_nxt    = mem_req_o;
        mem_addr_nxt   = mem_addr_o;
        mem_wdata_nxt  = mem_wdata_o;
        mem_we_nxt     = mem_we_o;
        sel_nxt        = sel_o;
        rdata_nxt      = rdata_o;
        busy_nxt       = busy_o;
        done0_nxt      = 1'b0;
        done1_nxt      = 1'b0;
        timeout_nxt    = 1'b0;
        last_grant_nxt = last_grant;
        cnt_nxt        = cnt;
        case (state)
            IDLE: begin
                if (any_req) begin
                    sel_nxt       = winner;
                    mem_addr_nxt  = winner ? addr1_i  : addr0_i;
                    mem_wdata_nxt = winner ? wdata1_i : wdata0_i;
                    mem_we_nxt    = winner ? we1_i    : we0_i;
                    mem_req_nxt   = 1'b1;
                    busy_nxt      = 1'b1;
                    cnt_nxt       = '0;
                end
            end
            BUSY: begin
                if (mem_ready_i || expire) begin
                    rdata_nxt      = mem_ready_i ? mem_rdata_i : '0;
                    timeout_nxt    = ~mem_ready_i;
                    done0_nxt      = (sel_o == GNT_IF);
                    done1_nxt      = (sel_o == GNT_MEM);
                    mem_req_nxt    = 1'b0;
                    last_grant_nxt = sel_o;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            DONE: begin
                busy_nxt = 1'b0;
            end
            default: begin
                busy_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mem_req_o   <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            mem_we_o    <= 1'b0;
            sel_o       <= 1'b0;
            rdata_o     <= '0;
            done0_o     <= 1'b0;
            done1_o     <= 1'b0;
            timeout_o   <= 1'b0;
            busy_o      <= 1'b0;
            last_grant  <= 1'b1;
            cnt         <= '0;
        end else begin
            mem_req_o   <= mem_req_nxt;
            mem_addr_o  <= mem_addr_nxt;
            mem_wdata_o <= mem_wdata_nxt;
            mem_we_o    <= mem_we_nxt;
            sel_o       <= sel_nxt;
            rdata_o     <= rdata_nxt;
            done0_o     <= done0_nxt;
            done1_o     <= done1_nxt;
            timeout_o   <= timeout_nxt;
            busy_o      <= busy_nxt;
            last_grant  <= last_grant_nxt;
            cnt         <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          req0_i = 1'b0, we0_i = 1'b0, req1_i = 1'b0, we1_i = 1'b0;
    logic [AW-1:0] addr0_i = '0, addr1_i = '0;
    logic [DW-1:0] wdata0_i = '0, wdata1_i = '0;
    logic          mem_ready_i = 1'b0;
    logic [DW-1:0] mem_rdata_i = '0;
    logic          mem_req_o, mem_we_o, sel_o, done0_o, done1_o, timeout_o, busy_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o, rdata_o;

    int n_checks = 0;
    int n_fail   = 0;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req0_i(req0_i), .addr0_i(addr0_i), .wdata0_i(wdata0_i), .we0_i(we0_i),
        .req1_i(req1_i), .addr1_i(addr1_i), .wdata1_i(wdata1_i), .we1_i(we1_i),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_we_o(mem_we_o), .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i),
        .sel_o(sel_o), .rdata_o(rdata_o), .done0_o(done0_o), .done1_o(done1_o),
        .timeout_o(timeout_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        #12;
        n_checks++;
        if ({mem_req_o, mem_we_o, sel_o, done0_o, done1_o, timeout_o, busy_o, mem_addr_o, mem_wdata_o, rdata_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got req=%b we=%b sel=%b d0=%b d1=%b to=%b busy=%b addr=%h wd=%h rd=%h exp all 0",
                     mem_req_o, mem_we_o, sel_o, done0_o, done1_o, timeout_o, busy_o, mem_addr_o, mem_wdata_o, rdata_o);
        end
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
    endtask

    task automatic test_basic_read();
        req0_i = 1'b1; addr0_i = 32'h100;
        step();
        n_checks++;
        if ({mem_req_o, sel_o, busy_o, mem_addr_o} !== {1'b1, 1'b0, 1'b1, 32'h100}) begin
            n_fail++;
            $display("FAIL basic_grant got req=%b sel=%b busy=%b addr=%h exp 1 0 1 00000100", mem_req_o, sel_o, busy_o, mem_addr_o);
        end
        mem_ready_i = 1'b1; mem_rdata_i = 32'hDEADBEEF;
        step();
        n_checks++;
        if ({done0_o, done1_o, timeout_o, mem_req_o, rdata_o} !== {4'b1000, 32'hDEADBEEF}) begin
            n_fail++;
            $display("FAIL basic_done got d0=%b d1=%b to=%b req=%b rd=%h exp 1 0 0 0 deadbeef", done0_o, done1_o, timeout_o, mem_req_o, rdata_o);
        end
        req0_i = 1'b0; mem_ready_i = 1'b0;
        step();
        n_checks++;
        if ({busy_o, done0_o, rdata_o} !== {2'b00, 32'hDEADBEEF}) begin
            n_fail++;
            $display("FAIL basic_idle got busy=%b d0=%b rd=%h exp 0 0 deadbeef", busy_o, done0_o, rdata_o);
        end
    endtask

    task automatic test_round_robin();
        int cnt0 = 0;
        int cnt1 = 0;
        logic exp_sel;
        rst_i = 1'b0; #2; rst_i = 1'b1;
        req0_i = 1'b1; req1_i = 1'b1; mem_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_sel = logic'(i % 2);
            step();
            n_checks++;
            if ({sel_o, mem_req_o} !== {exp_sel, 1'b1}) begin
                n_fail++;
                $display("FAIL rr_grant%0d got sel=%b req=%b exp %b 1", i, sel_o, mem_req_o, exp_sel);
            end
            step();
            n_checks++;
            if ({done0_o, done1_o} !== {~exp_sel, exp_sel}) begin
                n_fail++;
                $display("FAIL rr_done%0d got d0=%b d1=%b exp %b %b", i, done0_o, done1_o, ~exp_sel, exp_sel);
            end
            if (done0_o) cnt0++;
            if (done1_o) cnt1++;
            if (exp_sel) req1_i = 1'b0; else req0_i = 1'b0;
            step();
            req0_i = 1'b1; req1_i = 1'b1;
        end
        req0_i = 1'b0; req1_i = 1'b0; mem_ready_i = 1'b0;
        n_checks++;
        if (cnt0 != 4 || cnt1 != 4) begin
            n_fail++;
            $display("FAIL rr_fairness got done0=%0d done1=%0d exp 4 4", cnt0, cnt1);
        end
    endtask

    task automatic test_write();
        req1_i = 1'b1; we1_i = 1'b1; addr1_i = 32'h40; wdata1_i = 32'h12345678;
        step();
        n_checks++;
        if ({mem_we_o, sel_o, mem_addr_o, mem_wdata_o} !== {2'b11, 32'h40, 32'h12345678}) begin
            n_fail++;
            $display("FAIL write_port got we=%b sel=%b addr=%h wd=%h exp 1 1 00000040 12345678", mem_we_o, sel_o, mem_addr_o, mem_wdata_o);
        end
        addr1_i = 32'hFFFF0000; wdata1_i = 32'h0; we1_i = 1'b0;
        step();
        n_checks++;
        if ({mem_we_o, mem_req_o, mem_addr_o, mem_wdata_o, done1_o} !== {2'b11, 32'h40, 32'h12345678, 1'b0}) begin
            n_fail++;
            $display("FAIL write_frozen got we=%b req=%b addr=%h wd=%h d1=%b exp 1 1 00000040 12345678 0", mem_we_o, mem_req_o, mem_addr_o, mem_wdata_o, done1_o);
        end
        mem_ready_i = 1'b1; mem_rdata_i = 32'h0000A5A5;
        step();
        n_checks++;
        if ({done0_o, done1_o, timeout_o, rdata_o} !== {3'b010, 32'h0000A5A5}) begin
            n_fail++;
            $display("FAIL write_done got d0=%b d1=%b to=%b rd=%h exp 0 1 0 0000a5a5", done0_o, done1_o, timeout_o, rdata_o);
        end
        req1_i = 1'b0; mem_ready_i = 1'b0;
        step();
        n_checks++;
        if ({done1_o, busy_o} !== 2'b00) begin
            n_fail++;
            $display("FAIL write_single_done got d1=%b busy=%b exp 0 0", done1_o, busy_o);
        end
    endtask

    task automatic test_timeout();
        req0_i = 1'b1; addr0_i = 32'h200; mem_ready_i = 1'b0;
        step();
        for (int c = 2; c <= 4; c++) begin
            step();
            n_checks++;
            if ({done0_o, timeout_o, busy_o, mem_req_o} !== 4'b0011) begin
                n_fail++;
                $display("FAIL timeout_wait%0d got d0=%b to=%b busy=%b req=%b exp 0 0 1 1", c, done0_o, timeout_o, busy_o, mem_req_o);
            end
        end
        step();
        n_checks++;
        if ({done0_o, done1_o, timeout_o, mem_req_o, rdata_o} !== {4'b1010, 32'h0}) begin
            n_fail++;
            $display("FAIL timeout_abort got d0=%b d1=%b to=%b req=%b rd=%h exp 1 0 1 0 00000000", done0_o, done1_o, timeout_o, mem_req_o, rdata_o);
        end
        req0_i = 1'b0;
        step();
        n_checks++;
        if ({busy_o, timeout_o, done0_o} !== 3'b000) begin
            n_fail++;
            $display("FAIL timeout_idle got busy=%b to=%b d0=%b exp 0 0 0", busy_o, timeout_o, done0_o);
        end
    endtask

    task automatic test_reset_mid_busy();
        req1_i = 1'b1; addr1_i = 32'h300; we1_i = 1'b1; wdata1_i = 32'hCAFE;
        step();
        n_checks++;
        if ({busy_o, sel_o, mem_we_o} !== 3'b111) begin
            n_fail++;
            $display("FAIL rstbusy_grant got busy=%b sel=%b we=%b exp 1 1 1", busy_o, sel_o, mem_we_o);
        end
        #2; rst_i = 1'b0; req0_i = 1'b1; we1_i = 1'b0; #1;
        n_checks++;
        if ({mem_req_o, mem_we_o, sel_o, done0_o, done1_o, timeout_o, busy_o, mem_addr_o, mem_wdata_o, rdata_o} !== '0) begin
            n_fail++;
            $display("FAIL rstbusy_async got req=%b we=%b sel=%b d0=%b d1=%b to=%b busy=%b addr=%h wd=%h rd=%h exp all 0",
                     mem_req_o, mem_we_o, sel_o, done0_o, done1_o, timeout_o, busy_o, mem_addr_o, mem_wdata_o, rdata_o);
        end
        mem_ready_i = 1'b1;
        step();
        n_checks++;
        if ({done0_o, done1_o, busy_o} !== 3'b000) begin
            n_fail++;
            $display("FAIL rstbusy_nodone got d0=%b d1=%b busy=%b exp 0 0 0", done0_o, done1_o, busy_o);
        end
        mem_ready_i = 1'b0;
        rst_i = 1'b1;
        step();
        n_checks++;
        if ({busy_o, sel_o} !== 2'b10) begin
            n_fail++;
            $display("FAIL rstbusy_tie got busy=%b sel=%b exp 1 0", busy_o, sel_o);
        end
        mem_ready_i = 1'b1;
        step();
        req0_i = 1'b0; req1_i = 1'b0; mem_ready_i = 1'b0;
        step();
    endtask

    task automatic test_stray_signals();
        logic [DW-1:0] held;
        held = rdata_o;
        mem_ready_i = 1'b1; mem_rdata_i = 32'h11111111;
        step();
        n_checks++;
        if ({done0_o, done1_o, busy_o, mem_req_o, rdata_o} !== {4'b0000, held}) begin
            n_fail++;
            $display("FAIL stray_ready got d0=%b d1=%b busy=%b req=%b rd=%h exp 0 0 0 0 %h", done0_o, done1_o, busy_o, mem_req_o, rdata_o, held);
        end
        mem_ready_i = 1'b0; req1_i = 1'b1; addr1_i = 32'h500; we1_i = 1'b0;
        step();
        req1_i = 1'b0;
        step();
        n_checks++;
        if ({busy_o, mem_req_o, sel_o, done1_o} !== 4'b1110) begin
            n_fail++;
            $display("FAIL stray_drop_busy got busy=%b req=%b sel=%b d1=%b exp 1 1 1 0", busy_o, mem_req_o, sel_o, done1_o);
        end
        mem_ready_i = 1'b1; mem_rdata_i = 32'h00000055;
        step();
        n_checks++;
        if ({done0_o, done1_o, timeout_o, rdata_o} !== {3'b010, 32'h55}) begin
            n_fail++;
            $display("FAIL stray_done got d0=%b d1=%b to=%b rd=%h exp 0 1 0 00000055", done0_o, done1_o, timeout_o, rdata_o);
        end
        mem_ready_i = 1'b0;
        step();
        n_checks++;
        if ({busy_o, done1_o} !== 2'b00) begin
            n_fail++;
            $display("FAIL stray_idle got busy=%b d1=%b exp 0 0", busy_o, done1_o);
        end
    endtask

    initial begin
        test_reset();
        test_basic_read();
        test_round_robin();
        test_write();
        test_timeout();
        test_reset_mid_busy();
        test_stray_signals();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
